// File: rtl/aes_pkg.sv
// Shared AES definitions: block width, iterative-core FSM encoding and the
// LANES legality check used by the multi-lane cores.
package aes_pkg;

  localparam int BLOCK_W = 128;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic bit lanes_legal(input int lanes);
    return (lanes == 1) || (lanes == 2) || (lanes == 4) || (lanes == 8) || (lanes == 16);
  endfunction

endpackage

// File: rtl/sbox_dual.sv
// Combinational 8-bit AES S-box / inverse S-box sharing one GF(2^8) inverter;
// the mode bit chooses which affine map sits in front of or behind it.
module sbox_dual (
  input  logic [7:0] value,
  input  logic       inverse,
  output logic [7:0] result
);

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 by repeated squaring; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] fwd_affine(input logic [7:0] b);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] s);
    return rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05;
  endfunction

  logic [7:0] pre;
  logic [7:0] mid;

  always_comb begin
    pre    = inverse ? inv_affine(value) : value;
    mid    = gf_inv(pre);
    result = inverse ? mid : fwd_affine(mid);
  end

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: substitutes LANES bytes of the 128-bit state per
// cycle, MSB-first, between a valid/ready input and a valid/ready output.
module sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BLOCK_W-1:0] bytesIn,
  input  logic               inverse,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [BLOCK_W-1:0] bytesOut,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy
);

  localparam int N_STEPS = 16 / LANES;
  localparam int GRP_W   = 8 * LANES;
  localparam int CNT_W   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;

  if (!lanes_legal(LANES)) begin : g_bad_lanes
    $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  logic [1:0]         st_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BLOCK_W-1:0] state_q;
  logic [BLOCK_W-1:0] state_d;
  logic               mode_q;
  logic [GRP_W-1:0]   in_grp;
  logic [GRP_W-1:0]   out_grp;
  logic               last_step;

  assign last_step = (cnt_q == CNT_W'(N_STEPS - 1));

  // Group select: the step counter picks which LANES bytes feed the S-boxes.
  always_comb begin
    in_grp = '0;
    for (int g = 0; g < N_STEPS; g++) begin
      if (cnt_q == CNT_W'(g)) in_grp = state_q[BLOCK_W-1-g*GRP_W -: GRP_W];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sbox_dual u_sbox (
      .value  (in_grp[GRP_W-1-8*l -: 8]),
      .inverse(mode_q),
      .result (out_grp[GRP_W-1-8*l -: 8])
    );
  end

  // Write-back: only the group enabled by the counter takes the S-box result.
  always_comb begin
    state_d = state_q;
    for (int g = 0; g < N_STEPS; g++) begin
      if (cnt_q == CNT_W'(g)) state_d[BLOCK_W-1-g*GRP_W -: GRP_W] = out_grp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= ST_IDLE;
      cnt_q   <= '0;
      state_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      case (st_q)
        ST_IDLE: begin
          if (in_valid) begin
            state_q <= bytesIn;
            mode_q  <= inverse;
            cnt_q   <= '0;
            st_q    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          state_q <= state_d;
          if (last_step) begin
            cnt_q <= '0;
            st_q  <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) st_q <= ST_IDLE;
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (st_q == ST_IDLE);
  assign out_valid = (st_q == ST_DONE);
  assign busy      = (st_q == ST_BUSY);
  assign bytesOut  = state_q;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Scoreboard bench for sub_bytes_iter with LANES = 4, 1 and 16 instances on a
// shared clock/reset; expected blocks come from brute-force S-box tables.
module tb_sub_bytes_iter;

  localparam int NI = 3;

  function automatic int lanes_of(input int i);
    return (i == 0) ? 4 : (i == 1) ? 1 : 16;
  endfunction

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] bin  [NI];
  logic [127:0] bout [NI];
  logic         inv  [NI];
  logic         iv   [NI];
  logic         ir   [NI];
  logic         ov   [NI];
  logic         ordy [NI];
  logic         bsy  [NI];
  logic [7:0]   ftab [256];
  logic [7:0]   itab [256];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           issued  [NI];
  int           got     [NI];
  int           dropped [NI];
  bit           rnd_rdy = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      for (int i = 0; i < NI; i++) ordy[i] = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string name, input int idx, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h want %0h (cycle %0d)", name, idx, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // Multiplicative inverse found by exhaustive search, then the affine map;
  // the inverse table is just the forward table read backwards.
  task automatic build_tables();
    logic [7:0] m, s;
    for (int x = 0; x < 256; x++) begin
      m = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) m = 8'(y);
      s = m ^ rotl(m, 1) ^ rotl(m, 2) ^ rotl(m, 3) ^ rotl(m, 4) ^ 8'h63;
      ftab[x] = s;
      itab[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] sub_ref(input logic [127:0] d, input logic m);
    logic [127:0] r;
    logic [7:0]   x;
    r = '0;
    for (int b = 0; b < 16; b++) begin
      x = d[127-8*b -: 8];
      r[127-8*b -: 8] = m ? itab[x] : ftab[x];
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  for (genvar i = 0; i < NI; i++) begin : g_dut
    localparam int L = lanes_of(i);
    localparam int N = 16 / L;
    logic [127:0] exp_q [$];
    int           acc_q [$];

    sub_bytes_iter #(.LANES(L)) dut (
      .clk      (clk),
      .rst      (rst),
      .bytesIn  (bin[i]),
      .inverse  (inv[i]),
      .in_valid (iv[i]),
      .in_ready (ir[i]),
      .bytesOut (bout[i]),
      .out_valid(ov[i]),
      .out_ready(ordy[i]),
      .busy     (bsy[i])
    );

    always @(negedge clk) begin
      int  age;
      bit  pend;
      if (rst) begin
        dropped[i] += exp_q.size();
        exp_q.delete();
        acc_q.delete();
      end else begin
        pend = (exp_q.size() != 0);
        age  = pend ? (cyc - acc_q[0]) : 0;
        chk("in_ready", i, ir[i], !pend);
        chk("busy", i, bsy[i], pend && age <= N);
        chk("out_valid", i, ov[i], pend && age >= N + 1);
        if (ov[i] && pend) begin
          chk("bytes_out", i, bout[i], exp_q[0]);
          if (ordy[i]) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
            got[i]++;
          end
        end
        if (iv[i] && ir[i]) begin
          exp_q.push_back(sub_ref(bin[i], inv[i]));
          acc_q.push_back(cyc);
        end
      end
    end
  end

  task automatic issue(input int i, input logic [127:0] d, input logic m);
    int t;
    t = 0;
    bin[i] = d;
    inv[i] = m;
    iv[i]  = 1'b1;
    @(negedge clk);
    while (!ir[i] && t < 300) begin
      t++;
      @(negedge clk);
    end
    if (!ir[i]) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout[%0d] got in_ready=0 want 1 within 300 cycles", i);
    end else begin
      issued[i]++;
    end
    @(posedge clk);
    #1;
    iv[i] = 1'b0;
  endtask

  task automatic wait_ov(input int i);
    int t;
    t = 0;
    @(negedge clk);
    while (!ov[i] && t < 300) begin
      t++;
      @(negedge clk);
    end
    if (!ov[i]) begin
      checks++;
      errors++;
      $display("FAIL out_timeout[%0d] got out_valid=0 want 1 within 300 cycles", i);
    end
  endtask

  task automatic wait_out(input int i, output logic [127:0] d);
    wait_ov(i);
    d = bout[i];
    @(posedge clk);
    #1;
  endtask

  task automatic rand_run(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      issue(i, rand128(), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    logic [127:0] d;
    logic [127:0] v0;
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      bin[i] = '0; inv[i] = 1'b0; iv[i] = 1'b0; ordy[i] = 1'b0;
      issued[i] = 0; got[i] = 0; dropped[i] = 0;
    end
    build_tables();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("rst_in_ready", i, ir[i], 1);
      chk("rst_out_valid", i, ov[i], 0);
      chk("rst_busy", i, bsy[i], 0);
      chk("rst_bytes_out", i, bout[i], 0);
    end
    @(posedge clk);
    #1;

    for (int i = 0; i < NI; i++) ordy[i] = 1'b1;
    issue(0, 128'h0, 1'b0);
    wait_out(0, d);
    chk("kat_zero_fwd_l4", 0, d, {16{8'h63}});
    issue(1, 128'h000102030405060708090a0b0c0d0e0f, 1'b0);
    wait_out(1, d);
    chk("kat_fwd_l1", 1, d, 128'h637c777bf26b6fc53001672bfed7ab76);
    issue(2, 128'h637c777bf26b6fc53001672bfed7ab76, 1'b1);
    wait_out(2, d);
    chk("kat_inv_l16", 2, d, 128'h000102030405060708090a0b0c0d0e0f);

    // Backpressure with a second block already waiting on the input.
    ordy[0] = 1'b0;
    issue(0, rand128(), 1'b0);
    bin[0] = rand128();
    inv[0] = 1'b1;
    iv[0]  = 1'b1;
    wait_ov(0);
    v0 = bout[0];
    repeat (10) begin
      @(negedge clk);
      chk("bp_hold", 0, bout[0], v0);
      chk("bp_valid", 0, ov[0], 1);
      chk("bp_in_ready", 0, ir[0], 0);
    end
    @(posedge clk);
    #1 ordy[0] = 1'b1;
    @(negedge clk);
    chk("bp_handshake_in_ready", 0, ir[0], 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_second_accept", 0, ir[0], 1);
    @(posedge clk);
    #1 iv[0] = 1'b0;
    issued[0]++;
    wait_out(0, d);

    // Inputs churn while the block is being substituted.
    issue(0, {16{8'h53}}, 1'b0);
    for (int k = 0; k < 3; k++) begin
      bin[0] = rand128();
      inv[0] = ~inv[0];
      iv[0]  = (k == 1);
      @(posedge clk);
      #1;
    end
    iv[0] = 1'b0;
    wait_out(0, d);
    chk("midbusy_ignore", 0, d, {16{8'hED}});

    // Reset during BUSY step 2 throws the block away.
    issue(0, rand128(), 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 0, ir[0], 1);
    chk("midrst_out_valid", 0, ov[0], 0);
    chk("midrst_bytes_out", 0, bout[0], 0);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1;

    rnd_rdy = 1'b1;
    fork
      rand_run(0, 25);
      rand_run(1, 12);
      rand_run(2, 25);
    join
    rnd_rdy = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) ordy[i] = 1'b1;
    repeat (60) @(negedge clk);
    for (int i = 0; i < NI; i++) chk("drain", i, got[i] + dropped[i], issued[i]);
    chk("reset_dropped_one", 0, dropped[0], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
